store_narrow: RTL and testbench

//  Store-side counterpart of the immediate/load extender: narrows a 32-bit register value to

---
 rtl/store_narrow_pkg.sv | 27 ++
 rtl/store_narrow_if.sv | 27 ++
 rtl/store_beat_sel.sv | 18 +
 rtl/store_narrow.sv | 136 +++++++++++++
 tb/tb_store_narrow.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/store_narrow_pkg.sv
// Shared definitions for the store narrowing path: size codes, FSM states and
// helpers for beat count and alignment.
package store_narrow_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_BAD = 2'b11;

    typedef enum logic [0:0] {StIdle, StBeat} state_e;

    function automatic logic [2:0] beats_for(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SIZE_BAD) ||
               (size == SIZE_H && addr_lo[0]) ||
               (size == SIZE_W && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/store_narrow_if.sv
// CPU-side store request and byte-wide bus signals of the store narrower.
interface store_narrow_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_we;
    logic              bus_ack;

    modport master (
        output req, size, addr, wdata, bus_ack,
        input  busy, done, err, bus_addr, bus_wdata, bus_we
    );

    modport slave (
        input  req, size, addr, wdata, bus_ack,
        output busy, done, err, bus_addr, bus_wdata, bus_we
    );

endinterface

// File: rtl/store_beat_sel.sv
// Little-endian byte-lane selector: picks byte lane of a 32-bit word.
module store_beat_sel (
    input  logic [31:0] data,
    input  logic [1:0]  lane,
    output logic [7:0]  lane_data
);

    always_comb begin
        lane_data = data[7:0];
        unique case (lane)
            2'd0: lane_data = data[7:0];
            2'd1: lane_data = data[15:8];
            2'd2: lane_data = data[23:16];
            2'd3: lane_data = data[31:24];
        endcase
    end

endmodule

// File: rtl/store_narrow.sv
// Narrows a register store to byte/half/word and emits it as byte beats on an
// 8-bit bus, stalling the pipeline until the store finishes or times out.
module store_narrow
    import store_narrow_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst_n,
    store_narrow_if.slave sif
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        last_q, last_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [7:0]        bus_wdata_q, bus_wdata_d;
    logic              bus_we_q, bus_we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              bad;
    logic              timeout;
    logic [31:0]       sel_data;
    logic [1:0]        sel_lane;
    logic [7:0]        sel_byte;

    store_beat_sel u_beat_sel (
        .data      (sel_data),
        .lane      (sel_lane),
        .lane_data (sel_byte)
    );

    always_comb begin
        bad      = misaligned(sif.size, sif.addr[1:0]);
        timeout  = (cnt_q == CntW'(TIMEOUT - 1));
        sif.busy = (state_q != StIdle) || (sif.req && !bad);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        // In IDLE the lane mux looks at the incoming word so beat 0 is ready on accept.
        sel_data    = wdata_q;
        sel_lane    = k_q + 2'd1;

        unique case (state_q)
            StIdle: begin
                sel_data = sif.wdata;
                sel_lane = 2'd0;
                if (sif.req) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = StBeat;
                        k_d         = 2'd0;
                        cnt_d       = '0;
                        last_d      = 2'(beats_for(sif.size) - 3'd1);
                        wdata_d     = sif.wdata;
                        bus_addr_d  = sif.addr;
                        bus_wdata_d = sel_byte;
                        bus_we_d    = 1'b1;
                    end
                end
            end
            StBeat: begin
                if (sif.bus_ack) begin
                    cnt_d = '0;
                    if (k_q == last_q) begin
                        state_d  = StIdle;
                        bus_we_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        k_d         = k_q + 2'd1;
                        bus_addr_d  = bus_addr_q + ADDR_W'(1);
                        bus_wdata_d = sel_byte;
                    end
                end else if (timeout) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    bus_we_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= 2'd0;
            last_q      <= 2'd0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign sif.bus_addr  = bus_addr_q;
    assign sif.bus_wdata = bus_wdata_q;
    assign sif.bus_we    = bus_we_q;
    assign sif.done      = done_q;
    assign sif.err       = err_q;

endmodule

// File: tb/tb_store_narrow.sv
// Directed and randomized stores against a beat-list reference model of the narrower.
module tb_store_narrow;
    import store_narrow_pkg::*;

    localparam int unsigned TO = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    store_narrow_if #(.ADDR_W(32)) sif ();

    store_narrow #(
        .ADDR_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic bit ref_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    // Called just after a clock edge; leaves the bench just after the next edge.
    task automatic idle_cycle();
        sif.req     = 1'b0;
        sif.bus_ack = 1'($urandom);
        #1;
        chkb("busy_idle", sif.busy, 1'b0);
        @(posedge clk); #1;
        chkb("done_idle", sif.done, 1'b0);
        chkb("err_idle", sif.err, 1'b0);
        chkb("we_idle", sif.bus_we, 1'b0);
    endtask

    // Issues one store in the current cycle; ends just after the edge that
    // starts the done (or err) cycle, with that cycle's outputs checked.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                            input int unsigned delay);
        bit          bad;
        bit          aborted;
        int unsigned nb;
        bad     = ref_bad(sz, a);
        nb      = 1 << sz;
        aborted = 1'b0;
        sif.req     = 1'b1;
        sif.size    = sz;
        sif.addr    = a;
        sif.wdata   = wd;
        sif.bus_ack = 1'($urandom);
        #1;
        chkb("busy_req", sif.busy, !bad);
        if (bad) begin
            @(posedge clk); #1;
            sif.req = 1'b0;
            chkb("err_bad", sif.err, 1'b1);
            chkb("done_bad", sif.done, 1'b0);
            chkb("we_bad", sif.bus_we, 1'b0);
            #1;
            chkb("busy_bad", sif.busy, 1'b0);
            return;
        end
        for (int k = 0; k < int'(nb) && !aborted; k++) begin
            for (int unsigned w = 0; w < TO; w++) begin
                @(posedge clk); #1;
                sif.req     = 1'($urandom);
                sif.size    = 2'($urandom);
                sif.addr    = $urandom;
                sif.wdata   = $urandom;
                sif.bus_ack = (w == delay);
                #1;
                chkb("we_beat", sif.bus_we, 1'b1);
                chk("addr_beat", sif.bus_addr, a + 32'(k));
                chk("data_beat", 32'(sif.bus_wdata), (wd >> (8 * k)) & 32'hFF);
                chkb("busy_beat", sif.busy, 1'b1);
                chkb("done_beat", sif.done, 1'b0);
                chkb("err_beat", sif.err, 1'b0);
                if (w == delay) break;
                if (w == TO - 1) aborted = 1'b1;
            end
        end
        @(posedge clk); #1;
        sif.req     = 1'b0;
        sif.bus_ack = 1'b0;
        chkb("done_end", sif.done, 1'b1);
        chkb("err_end", sif.err, aborted);
        chkb("we_end", sif.bus_we, 1'b0);
    endtask

    initial begin
        logic [1:0]  rsz;
        logic [31:0] raddr;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        sif.req     = 1'b0;
        sif.size    = 2'b00;
        sif.addr    = '0;
        sif.wdata   = '0;
        sif.bus_ack = 1'b0;
        #2;
        chkb("rst_we", sif.bus_we, 1'b0);
        chk("rst_addr", sif.bus_addr, 32'h0);
        chk("rst_wdata", 32'(sif.bus_wdata), 32'h0);
        chkb("rst_done", sif.done, 1'b0);
        chkb("rst_err", sif.err, 1'b0);
        chkb("rst_busy", sif.busy, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        do_store(SIZE_W, 32'h0000_1000, 32'hA1B2_C3D4, 0);
        idle_cycle();
        do_store(SIZE_B, 32'h0000_2003, 32'h1234_56EF, 0);
        idle_cycle();
        do_store(SIZE_H, 32'h0000_3001, 32'hDEAD_BEEF, 0);
        do_store(SIZE_W, 32'h0000_3002, 32'hDEAD_BEEF, 0);
        do_store(SIZE_BAD, 32'h0000_3000, 32'hDEAD_BEEF, 0);
        idle_cycle();
        // Ack on the last allowed wait cycle: ack must beat the timeout.
        do_store(SIZE_H, 32'h0000_4000, 32'h0000_BEEF, TO - 1);
        idle_cycle();
        do_store(SIZE_W, 32'h0000_4100, 32'h5566_7788, TO + 3);
        idle_cycle();
        do_store(SIZE_B, 32'h0000_4200, 32'h0000_0011, 0);
        do_store(SIZE_B, 32'h0000_4201, 32'h0000_0022, 1);
        idle_cycle();

        // Reset asserted while beat 2 of a word store is on the bus.
        sif.req   = 1'b1;
        sif.size  = SIZE_W;
        sif.addr  = 32'h0000_5000;
        sif.wdata = 32'h1122_3344;
        @(posedge clk); #1;
        sif.req     = 1'b0;
        sif.bus_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sif.bus_ack = 1'b0;
        chk("rst_mid_addr", sif.bus_addr, 32'h0000_5002);
        chk("rst_mid_data", 32'(sif.bus_wdata), 32'h22);
        rst_n = 1'b0;
        #1;
        chkb("rst_mid_we", sif.bus_we, 1'b0);
        chkb("rst_mid_busy", sif.busy, 1'b0);
        chkb("rst_mid_done", sif.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chkb("post_rst_we", sif.bus_we, 1'b0);
        chkb("post_rst_done", sif.done, 1'b0);
        chkb("post_rst_err", sif.err, 1'b0);
        do_store(SIZE_B, 32'h0000_6001, 32'h0000_00A5, 0);
        idle_cycle();

        for (int i = 0; i < 30; i++) begin
            rsz   = 2'($urandom);
            raddr = $urandom;
            if ($urandom_range(0, 2) != 0) raddr = raddr & ~32'h3;
            do_store(rsz, raddr, $urandom, $urandom_range(0, TO));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
